// File: rtl/tx_frame_serializer_if.sv
// Transmit-side handshake bundle between the flip-code logic and the frame
// serializer.
//   Tx_Data  : payload slice of the transmit word
//   Tx_Flip  : flip pattern aligned with Tx_Data
//   Tx_Valid : source holds a frame to send
//   Tx_Ready : serializer can take a frame this cycle
// master = frame source, slave = serializer.
interface tx_frame_serializer_if #(
  parameter int PAYLOAD_W = 10,
  parameter int FLIP_W    = 7
);
  logic [PAYLOAD_W-1:0] Tx_Data;
  logic [FLIP_W-1:0]    Tx_Flip;
  logic                 Tx_Valid;
  logic                 Tx_Ready;

  modport master (output Tx_Data, output Tx_Flip, output Tx_Valid, input Tx_Ready);
  modport slave  (input Tx_Data, input Tx_Flip, input Tx_Valid, output Tx_Ready);
endinterface

// File: rtl/tx_frame_serializer.sv
// Frame serializer: accepts one {Tx_Flip, Tx_Data} word per frame over a
// valid/ready handshake and shifts it out as
//   start(0) | flip LSB first | data LSB first | even parity | stop(1)
// with every bit held for BAUD_DIV clocks.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tx           : handshake bundle (slave side)
//   Tx_Serial    : registered serial line, idles high
//   Tx_Busy      : a frame is in flight
//   Tx_Done      : high during the last clock of the stop bit
//   Tx_Frame_Cnt : completed-frame counter, wraps
module tx_frame_serializer #(
  parameter int PAYLOAD_W = 10,
  parameter int FLIP_W    = 7,
  parameter int BAUD_DIV  = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_frame_serializer_if.slave tx,
  output logic                 Tx_Serial,
  output logic                 Tx_Busy,
  output logic                 Tx_Done,
  output logic [CNT_W-1:0]     Tx_Frame_Cnt
);

  localparam int SH_W   = FLIP_W + PAYLOAD_W + 1;
  localparam int MAX_W  = (FLIP_W > PAYLOAD_W) ? FLIP_W : PAYLOAD_W;
  localparam int BIT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FLIP, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [SH_W-1:0]   shreg;     // {parity, data, flip}; bit 0 is next to send
  logic [BIT_W-1:0]  bit_cnt;   // bit index within FLIP or DATA
  logic [BAUD_W-1:0] baud_cnt;  // clock index within the current bit
  logic              accept;
  logic              baud_end;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    baud_end  = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
    case (state)
      S_IDLE: begin
        accept = tx.Tx_Valid;
        if (accept) state_nxt = S_START;
      end
      S_START:  if (baud_end) state_nxt = S_FLIP;
      S_FLIP:   if (baud_end && bit_cnt == BIT_W'(FLIP_W - 1)) state_nxt = S_DATA;
      S_DATA:   if (baud_end && bit_cnt == BIT_W'(PAYLOAD_W - 1)) state_nxt = S_PARITY;
      S_PARITY: if (baud_end) state_nxt = S_STOP;
      S_STOP:   if (baud_end) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign tx.Tx_Ready = (state == S_IDLE);
  assign Tx_Busy     = (state != S_IDLE);
  // Decoded from registers only, so it is a clean one-clock pulse that ends
  // on the same edge that returns the FSM to IDLE.
  assign Tx_Done     = (state == S_STOP) && baud_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      baud_cnt     <= '0;
      Tx_Serial    <= 1'b1;
      Tx_Frame_Cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Capture everything at the accept edge; inputs are don't-care after.
        shreg     <= {^{tx.Tx_Data, tx.Tx_Flip}, tx.Tx_Data, tx.Tx_Flip};
        Tx_Serial <= 1'b0;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (state != S_IDLE) begin
        if (!baud_end) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          bit_cnt  <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
          case (state)
            // The bit after START/FLIP/DATA always comes from the shifter;
            // after the last data bit only the parity bit is left in it.
            S_START, S_FLIP, S_DATA: begin
              Tx_Serial <= shreg[0];
              shreg     <= shreg >> 1;
            end
            S_PARITY: Tx_Serial <= 1'b1;
            S_STOP: begin
              Tx_Serial    <= 1'b1;
              Tx_Frame_Cnt <= Tx_Frame_Cnt + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer: one instance at BAUD_DIV=4 and one
// at BAUD_DIV=1, each on its own handshake interface.
module tb_tx_frame_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_frame_serializer_if #(.PAYLOAD_W(10), .FLIP_W(7)) if4 ();
  tx_frame_serializer_if #(.PAYLOAD_W(10), .FLIP_W(7)) if1 ();

  logic       ser4, busy4, done4;
  logic [7:0] cnt4;
  logic       ser1, busy1, done1;
  logic [7:0] cnt1;

  tx_frame_serializer #(.PAYLOAD_W(10), .FLIP_W(7), .BAUD_DIV(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .tx(if4),
    .Tx_Serial(ser4), .Tx_Busy(busy4), .Tx_Done(done4), .Tx_Frame_Cnt(cnt4)
  );

  tx_frame_serializer #(.PAYLOAD_W(10), .FLIP_W(7), .BAUD_DIV(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .tx(if1),
    .Tx_Serial(ser1), .Tx_Busy(busy1), .Tx_Done(done1), .Tx_Frame_Cnt(cnt1)
  );

  int total = 0;
  int bad   = 0;

  // Per-cycle samples, index j = sample taken 1 ns after the j-th edge.
  logic ser_q  [0:299];
  logic done_q [0:299];
  logic rdy_q  [0:299];
  logic busy_q [0:299];

  // Hand-derived bit streams, index 0 is transmitted first.
  localparam logic [0:19] EXP1 = 20'b0_1010000_1010010101_1_1;  // flip 05, data 2A5
  localparam logic [0:19] EXP2 = 20'b0_0000000_0000000000_0_1;  // all zero
  localparam logic [0:19] EXP6 = 20'b0_0000101_1111111111_0_1;  // flip 50, data 3FF

  function automatic logic [0:19] build_frame(input logic [6:0] f, input logic [9:0] d);
    logic [0:19] r;
    r[0] = 1'b0;
    for (int i = 0; i < 7; i++)  r[1+i] = f[i];
    for (int i = 0; i < 10; i++) r[8+i] = d[i];
    r[18] = ^{f, d};
    r[19] = 1'b1;
    return r;
  endfunction

  function automatic logic [9:0] dseq(input int c);
    return 10'(c * 37 + 5);
  endfunction

  function automatic logic [6:0] fseq(input int c);
    return 7'(c * 13 + 1);
  endfunction

  // Observed frame taken mid-bit.
  function automatic logic [0:19] frame_from(input int base, input int bd);
    logic [0:19] r;
    for (int b = 0; b < 20; b++) r[b] = ser_q[base + b*bd + bd/2];
    return r;
  endfunction

  // Cycles in a frame window whose serial level differs from the expected bit.
  function automatic int frame_errs(input int base, input int bd, input logic [0:19] exp);
    int n = 0;
    for (int b = 0; b < 20; b++)
      for (int k = 0; k < bd; k++)
        if (ser_q[base + b*bd + k] !== exp[b]) n++;
    return n;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [6:0] f, input logic [9:0] d);
    if (sel == 0) begin
      if4.Tx_Valid = v; if4.Tx_Flip = f; if4.Tx_Data = d;
    end else begin
      if1.Tx_Valid = v; if1.Tx_Flip = f; if1.Tx_Data = d;
    end
  endtask

  // Runs ncyc edges starting with the accept edge. Mid-frame, Tx_Valid stays
  // high with X data to show it is ignored; it drops after the last sample.
  task automatic capture(input int sel, input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk); #1;
      ser_q[j]  = (sel == 0) ? ser4  : ser1;
      done_q[j] = (sel == 0) ? done4 : done1;
      rdy_q[j]  = (sel == 0) ? if4.Tx_Ready : if1.Tx_Ready;
      busy_q[j] = (sel == 0) ? busy4 : busy1;
      if (j == ncyc - 1) drive(sel, 1'b0, '0, '0);
      else               drive(sel, 1'b1, 'x, 'x);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ser4 !== 1'b1)        begin bad++; $display("FAIL rst_ser4 got=%b exp=1", ser4); end
    total++; if (if4.Tx_Ready !== 1'b1) begin bad++; $display("FAIL rst_rdy4 got=%b exp=1", if4.Tx_Ready); end
    total++; if (busy4 !== 1'b0)       begin bad++; $display("FAIL rst_busy4 got=%b exp=0", busy4); end
    total++; if (done4 !== 1'b0)       begin bad++; $display("FAIL rst_done4 got=%b exp=0", done4); end
    total++; if (cnt4 !== 8'd0)        begin bad++; $display("FAIL rst_cnt4 got=%0d exp=0", cnt4); end
    total++; if (ser1 !== 1'b1)        begin bad++; $display("FAIL rst_ser1 got=%b exp=1", ser1); end
    total++; if (if1.Tx_Ready !== 1'b1) begin bad++; $display("FAIL rst_rdy1 got=%b exp=1", if1.Tx_Ready); end
    total++; if (cnt1 !== 8'd0)        begin bad++; $display("FAIL rst_cnt1 got=%0d exp=0", cnt1); end
    #4 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n;
    drive(0, 1'b1, 7'h05, 10'h2A5);
    capture(0, 81);
    total++;
    if (frame_errs(0, 4, EXP1) != 0) begin
      bad++; $display("FAIL t1_frame got=%b exp=%b", frame_from(0, 4), EXP1);
    end
    n = 0;
    for (int j = 0; j < 81; j++) if (done_q[j] !== (j == 79)) n++;
    total++; if (n != 0) begin bad++; $display("FAIL t1_done_timing wrong_cycles=%0d exp=0", n); end
    n = 0;
    for (int j = 0; j < 80; j++) if (rdy_q[j] !== 1'b0 || busy_q[j] !== 1'b1) n++;
    total++; if (n != 0) begin bad++; $display("FAIL t1_busy_window wrong_cycles=%0d exp=0", n); end
    total++; if (rdy_q[80] !== 1'b1 || busy_q[80] !== 1'b0 || ser_q[80] !== 1'b1) begin
      bad++; $display("FAIL t1_end rdy=%b busy=%b ser=%b exp=1,0,1", rdy_q[80], busy_q[80], ser_q[80]);
    end
    total++; if (cnt4 !== 8'd1) begin bad++; $display("FAIL t1_cnt got=%0d exp=1", cnt4); end
  endtask

  task automatic test_zero;
    int n;
    drive(0, 1'b1, 7'h00, 10'h000);
    capture(0, 81);
    total++;
    if (frame_errs(0, 4, EXP2) != 0) begin
      bad++; $display("FAIL t2_frame got=%b exp=%b", frame_from(0, 4), EXP2);
    end
    n = 0;
    for (int j = 0; j < 80; j++) if (rdy_q[j] !== 1'b0) n++;
    total++; if (n != 0) begin bad++; $display("FAIL t2_ready_low ready_high_cycles=%0d exp=0", n); end
    total++; if (rdy_q[80] !== 1'b1) begin bad++; $display("FAIL t2_ready_back got=%b exp=1", rdy_q[80]); end
    total++; if (cnt4 !== 8'd2) begin bad++; $display("FAIL t2_cnt got=%0d exp=2", cnt4); end
  endtask

  task automatic test_back_to_back;
    int starts [0:7];
    int ns, nd, nbad_done;
    logic [7:0] cnt_before;
    cnt_before = cnt4;
    for (int c = 0; c < 243; c++) begin
      drive(0, 1'b1, fseq(c), dseq(c));
      @(posedge clk); #1;
      ser_q[c]  = ser4;
      busy_q[c] = busy4;
      done_q[c] = done4;
    end
    drive(0, 1'b0, '0, '0);
    ns = 0;
    for (int c = 0; c < 243; c++)
      if (busy_q[c] === 1'b1 && (c == 0 || busy_q[c-1] === 1'b0)) begin
        if (ns < 8) starts[ns] = c;
        ns++;
      end
    total++; if (ns != 3) begin bad++; $display("FAIL t3_frame_count got=%0d exp=3", ns); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (k < ns && starts[k] != k*81) begin
        bad++; $display("FAIL t3_start%0d got=%0d exp=%0d", k, starts[k], k*81);
      end else if (k >= ns) begin
        bad++; $display("FAIL t3_start%0d got=missing exp=%0d", k, k*81);
      end
      total++;
      if (frame_errs(k*81, 4, build_frame(fseq(k*81), dseq(k*81))) != 0) begin
        bad++; $display("FAIL t3_frame%0d got=%b exp=%b", k, frame_from(k*81, 4),
                        build_frame(fseq(k*81), dseq(k*81)));
      end
    end
    nd = 0; nbad_done = 0;
    for (int c = 0; c < 243; c++) begin
      if (done_q[c] === 1'b1) nd++;
      if (done_q[c] !== (c == 79 || c == 160 || c == 241)) nbad_done++;
    end
    total++; if (nbad_done != 0) begin bad++; $display("FAIL t3_done pulses=%0d wrong_cycles=%0d exp=3,0", nd, nbad_done); end
    total++; if (cnt4 !== 8'(cnt_before + 3)) begin
      bad++; $display("FAIL t3_cnt got=%0d exp=%0d", cnt4, 8'(cnt_before + 3));
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    drive(0, 1'b1, 7'h33, 10'h155);
    capture(0, 30);
    #2 rst = 1'b1;
    #1;
    total++; if (ser4 !== 1'b1) begin bad++; $display("FAIL t4_ser_immediate got=%b exp=1", ser4); end
    total++; if (done4 !== 1'b0 || busy4 !== 1'b0 || if4.Tx_Ready !== 1'b1) begin
      bad++; $display("FAIL t4_ctrl done=%b busy=%b rdy=%b exp=0,0,1", done4, busy4, if4.Tx_Ready);
    end
    total++; if (cnt4 !== 8'd0) begin bad++; $display("FAIL t4_cnt_cleared got=%0d exp=0", cnt4); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 7'h2B, 10'h0F0);
    capture(0, 81);
    total++;
    if (frame_errs(0, 4, build_frame(7'h2B, 10'h0F0)) != 0) begin
      bad++; $display("FAIL t4_frame got=%b exp=%b", frame_from(0, 4), build_frame(7'h2B, 10'h0F0));
    end
    n = 0;
    for (int j = 0; j < 81; j++) if (done_q[j] !== (j == 79)) n++;
    total++; if (n != 0) begin bad++; $display("FAIL t4_done wrong_cycles=%0d exp=0", n); end
    total++; if (cnt4 !== 8'd1) begin bad++; $display("FAIL t4_cnt got=%0d exp=1", cnt4); end
  endtask

  task automatic test_counter_wrap;
    int dones = 0;
    bit timed_out = 0;
    rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int f = 1; f <= 256 && !timed_out; f++) begin
      drive(0, 1'b1, 7'(f), ~10'(f));
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0);
      timed_out = 1;
      for (int w = 0; w < 100; w++) begin
        @(posedge clk); #1;
        if (done4 === 1'b1) dones++;
        if (if4.Tx_Ready === 1'b1) begin timed_out = 0; break; end
      end
      if (timed_out) begin
        total++; bad++; $display("FAIL t5_timeout frame=%0d got=no_ready exp=ready", f);
      end
      if (f == 255) begin
        total++; if (cnt4 !== 8'd255) begin bad++; $display("FAIL t5_cnt255 got=%0d exp=255", cnt4); end
      end
      if (f == 256) begin
        total++; if (cnt4 !== 8'd0) begin bad++; $display("FAIL t5_cnt_wrap got=%0d exp=0", cnt4); end
      end
    end
    total++; if (dones != 256) begin bad++; $display("FAIL t5_done_count got=%0d exp=256", dones); end
  endtask

  task automatic test_baud1;
    int n;
    drive(1, 1'b1, 7'h50, 10'h3FF);
    capture(1, 21);
    total++;
    if (frame_errs(0, 1, EXP6) != 0) begin
      bad++; $display("FAIL t6_frame got=%b exp=%b", frame_from(0, 1), EXP6);
    end
    total++; if (ser_q[18] !== 1'b0) begin bad++; $display("FAIL t6_parity got=%b exp=0", ser_q[18]); end
    n = 0;
    for (int j = 0; j < 21; j++) if (done_q[j] !== (j == 19)) n++;
    total++; if (n != 0) begin bad++; $display("FAIL t6_done wrong_cycles=%0d exp=0", n); end
    total++; if (rdy_q[19] !== 1'b0 || rdy_q[20] !== 1'b1 || busy_q[20] !== 1'b0) begin
      bad++; $display("FAIL t6_len rdy19=%b rdy20=%b busy20=%b exp=0,1,0", rdy_q[19], rdy_q[20], busy_q[20]);
    end
    total++; if (cnt1 !== 8'd1) begin bad++; $display("FAIL t6_cnt got=%0d exp=1", cnt1); end
  endtask

  initial begin
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    test_reset;
    test_basic;
    test_zero;
    test_back_to_back;
    test_reset_mid_frame;
    test_counter_wrap;
    test_baud1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_frame_serializer.md
Name: tx_frame_serializer

Overview:
- Transmit stage directly downstream of the Tx flip-code logic.
- Each frame it accepts one low payload slice Tx_Data[9:0] together with the 7-bit Tx_Flip pattern that the flip-code logic produced from Tx_Data[15:10] for the same word.
- It builds a framed, parity-protected bit stream and shifts it out on a single serial line at a programmable bit rate.
- It uses a valid/ready handshake and has a frame counter for link statistics.

Parameters:
- PAYLOAD_W, 10: payload bits per frame (Tx_Data width).
- FLIP_W, 7: flip-pattern bits per frame (Tx_Flip width).
- BAUD_DIV, 4: clocks per serial bit; legal values ≥1.
- CNT_W, 8: width of the frame counter.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- Tx_Data, input, PAYLOAD_W: payload bits [9:0] of the transmit word.
- Tx_Flip, input, FLIP_W: flip pattern from the flip-code logic, aligned with Tx_Data.
- Tx_Valid, input, 1: Tx_Data/Tx_Flip hold a frame to send.
- Tx_Ready, output, 1: block can accept a frame this cycle.
- Tx_Serial, output, 1: serial line output, registered; idle level 1.
- Tx_Busy, output, 1: a frame is in flight.
- Tx_Done, output, 1: one-cycle pulse on the last clock of the stop bit.
- Tx_Frame_Cnt, output, CNT_W: count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - State goes to IDLE; the frame is discarded with no Tx_Done.
  - Tx_Serial=1, Tx_Ready=1, Tx_Busy=0, Tx_Done=0, Tx_Frame_Cnt=0.
  - Shift register, bit counter and baud counter are cleared.
- Frame format, total 2+FLIP_W+PAYLOAD_W+1 bits (20 by default), sent in this order:
  - Start bit: 0.
  - Tx_Flip[0..FLIP_W-1], LSB first.
  - Tx_Data[0..PAYLOAD_W-1], LSB first.
  - Parity bit: even parity, i.e. XOR of all FLIP_W+PAYLOAD_W data bits.
  - Stop bit: 1.
- Handshake:
  - Tx_Ready = 1 only in IDLE.
  - Accept occurs on a rising edge where Tx_Valid && Tx_Ready.
  - At the accept edge, Tx_Flip, Tx_Data and the computed parity are captured.
  - After acceptance, inputs are don't-care and later input changes never affect the frame in flight.
  - Tx_Valid outside IDLE is ignored; it is not queued.
- Timing:
  - On the accept edge: Tx_Serial←0 (start bit), Tx_Busy←1, Tx_Ready←0.
  - Each bit is held for exactly BAUD_DIV clocks, timed by a baud counter that counts 0..BAUD_DIV-1.
  - The frame spans exactly 20×BAUD_DIV clocks, starting at the accept edge.
- FSM:
  - IDLE → START on accept.
  - START → FLIP after 1 bit time.
  - FLIP → DATA after FLIP_W bits.
  - DATA → PARITY after PAYLOAD_W bits.
  - PARITY → STOP after 1 bit.
  - STOP → IDLE after 1 bit.
- End of frame:
  - On the edge that ends STOP: Tx_Done=1 for exactly one clock; Tx_Frame_Cnt increments (255→0 at CNT_W=8).
  - Tx_Busy falls and Tx_Ready rises on that same edge.
  - Earliest next accept is the following edge, so the minimum inter-frame idle is 1 clock at level 1.
- BAUD_DIV=1: each bit lasts one clock; the frame lasts 20 clocks.
- Tx_Valid high with X data while Tx_Ready=0 must not change any output.

Test Plan:
1. Reset, then Tx_Flip=7'h05, Tx_Data=10'h2A5, Tx_Valid pulse, BAUD_DIV=4. Tx_Serial carries 0 | 1,0,1,0,0,0,0 | 1,0,1,0,0,1,0,1,0,1 | parity 1 | stop 1, each bit 4 clocks. Tx_Done pulses 80 clocks after accept; Tx_Frame_Cnt=1.
2. Tx_Flip=0, Tx_Data=0. Frame is a start 0, seventeen 0s, parity 0 and stop 1. Tx_Ready is low throughout and returns high after 80 clocks.
3. Tx_Valid held high continuously while Tx_Data changes every clock. Only the value present at each accept edge is sent. Consecutive start bits are exactly 81 clocks apart, and no frame is dropped or duplicated.
4. Assert rst at clock 30 of a frame. Tx_Serial=1 immediately, with no Tx_Done and Tx_Frame_Cnt=0. The next accepted frame is sent completely and correctly.
5. Send 256 frames with CNT_W=8. Tx_Frame_Cnt reads 255 after 255 frames and 0 after the 256th, with 256 Tx_Done pulses in total.
6. BAUD_DIV=1, Tx_Flip=7'h50, Tx_Data=10'h3FF. The frame lasts 20 clocks and the parity bit is 0 (12 ones). Tx_Done falls on clock 20.
